// File: rtl/eth_rx_filter_pkg.sv
// Shared types and constants for the RX destination-address filter.
package eth_rx_filter_pkg;

  typedef enum logic [1:0] {
    ST_HDR    = 2'd0,
    ST_REPLAY = 2'd1,
    ST_PASS   = 2'd2,
    ST_DROP   = 2'd3
  } state_e;

  localparam int          MAC_BYTES = 6;
  localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;

  // Group (multicast/broadcast) addresses carry the I/G bit in the first wire byte.
  function automatic logic is_group(input logic [47:0] addr);
    return addr[40];
  endfunction

endpackage

// File: rtl/eth_mac_match.sv
// Combinational destination-address match: own MAC, broadcast, or any group address when enabled.
module eth_mac_match
  import eth_rx_filter_pkg::*;
(
  input  logic [47:0] dest,
  input  logic [47:0] mac,
  input  logic        mcast_en,
  output logic        match
);

  // Address acceptance decision.
  always_comb begin
    match = (dest == mac) | (dest == BCAST_MAC) | (mcast_en & is_group(dest));
  end

endmodule

// File: rtl/eth_rx_mac_filter.sv
// RX frame filter: buffers the 6-byte destination, then replays and forwards or discards the frame.
// Frame counters are built only when ETH_RX_MAC_FILTER_CNT_EN is defined; otherwise they read 0.
module eth_rx_mac_filter
  import eth_rx_filter_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 s_axis_tlast,
  input  logic                 s_axis_tuser,
  output logic [7:0]           m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tuser,
  input  logic [47:0]          mac_addr_i,
  input  logic                 accept_mcast_i,
  output logic [CNT_WIDTH-1:0] pass_cnt_o,
  output logic [CNT_WIDTH-1:0] drop_cnt_o
);

  localparam logic [2:0] LAST_IDX = 3'(MAC_BYTES - 1);

  state_e      state_r;
  state_e      state_nxt_s;
  logic [2:0]  idx_r;
  logic [2:0]  idx_nxt_s;
  logic [7:0]  hdr_r [MAC_BYTES];
  logic [47:0] dest_s;
  logic        match_s;
  logic        pass_ev_s;
  logic        drop_ev_s;

  // The sixth byte is still on the bus when the decision is made, so it joins the five buffered ones.
  assign dest_s = {hdr_r[0], hdr_r[1], hdr_r[2], hdr_r[3], hdr_r[4], s_axis_tdata};

  eth_mac_match u_match (
    .dest     (dest_s),
    .mac      (mac_addr_i),
    .mcast_en (accept_mcast_i),
    .match    (match_s)
  );

  // State and header index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_HDR;
      idx_r   <= 3'd0;
    end else begin
      state_r <= state_nxt_s;
      idx_r   <= idx_nxt_s;
    end
  end

  // Header capture buffer, written only while collecting the destination.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAC_BYTES; i++) begin
        hdr_r[i] <= 8'h00;
      end
    end else if ((state_r == ST_HDR) && s_axis_tvalid) begin
      hdr_r[idx_r] <= s_axis_tdata;
    end
  end

  // Next-state, handshake and output-mux logic.
  always_comb begin
    state_nxt_s   = state_r;
    idx_nxt_s     = idx_r;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = 8'h00;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    pass_ev_s     = 1'b0;
    drop_ev_s     = 1'b0;
    case (state_r)
      ST_HDR: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid) begin
          if (s_axis_tlast) begin
            drop_ev_s = 1'b1;
            idx_nxt_s = 3'd0;
          end else if (idx_r == LAST_IDX) begin
            idx_nxt_s   = 3'd0;
            state_nxt_s = match_s ? ST_REPLAY : ST_DROP;
          end else begin
            idx_nxt_s = idx_r + 3'd1;
          end
        end else begin
          idx_nxt_s = idx_r;
        end
      end
      ST_REPLAY: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = hdr_r[idx_r];
        if (m_axis_tready) begin
          if (idx_r == LAST_IDX) begin
            idx_nxt_s   = 3'd0;
            state_nxt_s = ST_PASS;
          end else begin
            idx_nxt_s = idx_r + 3'd1;
          end
        end else begin
          idx_nxt_s = idx_r;
        end
      end
      ST_PASS: begin
        s_axis_tready = m_axis_tready;
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tdata  = s_axis_tdata;
        m_axis_tlast  = s_axis_tlast;
        m_axis_tuser  = s_axis_tuser;
        if (s_axis_tvalid && m_axis_tready && s_axis_tlast) begin
          pass_ev_s   = 1'b1;
          state_nxt_s = ST_HDR;
        end else begin
          state_nxt_s = ST_PASS;
        end
      end
      ST_DROP: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) begin
          drop_ev_s   = 1'b1;
          state_nxt_s = ST_HDR;
        end else begin
          state_nxt_s = ST_DROP;
        end
      end
      default: begin
        state_nxt_s = ST_HDR;
        idx_nxt_s   = 3'd0;
      end
    endcase
  end

`ifdef ETH_RX_MAC_FILTER_CNT_EN
  logic [CNT_WIDTH-1:0] pass_cnt_r;
  logic [CNT_WIDTH-1:0] drop_cnt_r;

  // Frame counters; wrap naturally at 2^CNT_WIDTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_cnt_r <= '0;
      drop_cnt_r <= '0;
    end else begin
      if (pass_ev_s) pass_cnt_r <= pass_cnt_r + CNT_WIDTH'(1);
      if (drop_ev_s) drop_cnt_r <= drop_cnt_r + CNT_WIDTH'(1);
    end
  end

  assign pass_cnt_o = pass_cnt_r;
  assign drop_cnt_o = drop_cnt_r;
`else
  logic unused_ev_s;

  assign unused_ev_s = pass_ev_s ^ drop_ev_s;
  assign pass_cnt_o  = '0;
  assign drop_cnt_o  = '0;
`endif

endmodule

// File: doc/eth_rx_mac_filter.md
ETH_RX_MAC_FILTER -- requirements
Module: eth_rx_mac_filter

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 32, width of frame counters.
REQ-002 SHALL have port clk  input  1  sole clock; all logic rising-edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports s_axis_tdata input 8, s_axis_tvalid input 1, s_axis_tready output 1, s_axis_tlast input 1, s_axis_tuser input 1: byte stream from the RX MAC.
REQ-005 SHALL have ports m_axis_tdata output 8, m_axis_tvalid output 1, m_axis_tready input 1, m_axis_tlast output 1, m_axis_tuser output 1: filtered stream to the RX async FIFO.
REQ-006 SHALL have port mac_addr_i  input  48  local MAC; first wire byte compares to [47:40].
REQ-007 SHALL have port accept_mcast_i  input  1  accept any group address (first byte bit 0 set).
REQ-008 SHALL have ports pass_cnt_o, drop_cnt_o  output  CNT_WIDTH  frames forwarded / discarded.

Function
REQ-009 SHALL implement states HDR, REPLAY, PASS, DROP; reset state HDR.
REQ-010 HDR: s_axis_tready=1, m_axis_tvalid=0; each accepted byte stored in 6-byte header buffer, index 0..5.
REQ-011 Accepted byte with tlast in HDR (index 0..5, incl. 6th byte) SHALL be a runt: drop_cnt +1, buffer index cleared, stay HDR.
REQ-012 On 6th byte accepted without tlast: match = (dest == mac_addr_i) | (dest == FF:FF:FF:FF:FF:FF) | (accept_mcast_i & dest[40]); mac_addr_i/accept_mcast_i sampled that cycle only.
REQ-013 match -> REPLAY next cycle; no match -> DROP next cycle.
REQ-014 REPLAY: s_axis_tready=0; m_axis_tvalid=1, m_axis_tdata=buffer[idx], tlast=0, tuser=0; idx advances on m handshake; after 6th handshake -> PASS.
REQ-015 PASS: combinational pass-through, m_axis_* = s_axis_*, s_axis_tready = m_axis_tready; on handshake with tlast: pass_cnt +1 -> HDR.
REQ-016 DROP: s_axis_tready=1, m_axis_tvalid=0; on accepted tlast: drop_cnt +1 -> HDR.
REQ-017 First forwarded byte SHALL appear one cycle after the 6th header byte is accepted; m_axis_tvalid SHALL NOT drop during REPLAY.
REQ-018 tuser SHALL pass unmodified on PASS beats; a frame with tuser=1 on tlast is still counted in pass_cnt.
REQ-019 Counters SHALL wrap modulo 2^CNT_WIDTH without saturation.
REQ-020 s_axis_tvalid low mid-frame in any state SHALL stall without state change.

Reset
REQ-021 rst_n low SHALL asynchronously force: state HDR, buffer index 0, counters 0, m_axis_tvalid 0, s_axis_tready 1 after release.
REQ-022 Reset mid-frame SHALL abandon the frame silently (no count); following bytes until next tlast are treated as a new header.

Configuration
REQ-023 Macro ETH_RX_MAC_FILTER_CNT_EN defined: pass_cnt_o/drop_cnt_o count per REQ-011/015/016.
REQ-024 Macro undefined: counter registers SHALL not be built; pass_cnt_o/drop_cnt_o tie to 0; filtering unchanged.

Structure
REQ-025 Package eth_rx_filter_pkg SHALL hold state enum, MAC_BYTES=6, BCAST_MAC=48'hFFFF_FFFF_FFFF.
REQ-026 Address compare SHALL be one combinational sub-module eth_mac_match (48-bit dest, mac, mcast enable -> match).

Verification
REQ-027 mac=02:00:00:00:00:01, frame 64 bytes to that dest, m_axis_tready=1 -> 64 bytes out identical, pass_cnt=1, drop_cnt=0.
REQ-028 Frame to 02:00:00:00:00:02 (40 bytes) -> no m_axis_tvalid, 40 bytes consumed, drop_cnt=1.
REQ-029 Broadcast frame, then group frame 01:00:5E:00:00:01 with accept_mcast_i=0 then 1 -> passes, drops, passes; pass_cnt=2, drop_cnt=1.
REQ-030 4-byte frame with tlast on byte 4, then 6-byte frame -> both dropped as runt, drop_cnt=2, no output.
REQ-031 Matching frame with m_axis_tready toggling every cycle and s_axis_tvalid gaps -> byte-exact output, no duplication or loss.
REQ-032 rst_n asserted at byte 20 of a matching frame -> m_axis_tvalid=0 immediately, counters 0; next full frame passes normally.
